mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
Data-memory access stage of the 5-stage RISC-V pipeline. It sits between the EX/MEM pipeline register and mem_wb_pipe. It takes the MemRead/MemWrite control, ALU address, store data and funct3, and runs a req/gnt/rvalid transaction on the data-memory bus. It produces the sign- or zero-extended load data that mem_wb_pipe captures as read_data_in, and stalls the pipeline while a transaction is outstanding.

Parameters:
TIMEOUT, 16, max cycles spent in REQ+WAIT_R before the access is abandoned with bus_err_out
CNT_W, 5, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT

Ports:
clk  in  1  pipeline clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
MemRead_in  in  1  load in MEM stage (from EX/MEM)
MemWrite_in  in  1  store in MEM stage (from EX/MEM)
funct3_in  in  3  access size/sign (RV32I load/store encoding)
address_in  in  32  byte address from ALU
write_data_in  in  32  store data (rs2)
mem_req  out  1  bus request
mem_we  out  1  1 = write
mem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
mem_wdata  out  32  lane-replicated store data
mem_wstrb  out  4  byte enables (0 on reads)
mem_gnt  in  1  request accepted when mem_req & mem_gnt at posedge
mem_rvalid  in  1  read data valid
mem_rdata  in  32  read word
read_data_out  out  32  extended load result to mem_wb_pipe
stall_out  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
bus_err_out  out  1  1-cycle pulse: access timed out
misalign_err_out  out  1  1-cycle pulse: misaligned access trapped (see Optional Feature)

Behaviour:
- FSM states: IDLE, REQ, WAIT_R, DONE. Reset (reset=0, async) forces IDLE. It clears mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, read_data_out, bus_err_out, misalign_err_out and the counter to 0. Reset mid-transaction abandons it; a later mem_rvalid is ignored.
- access = MemRead_in | MemWrite_in. If both are set, the access is treated as a write.
- stall_out (combinational) = (state==IDLE & access) | state==REQ | state==WAIT_R. It is 0 in DONE, so the pipeline advances on the DONE edge and mem_wb_pipe captures read_data_out.
- IDLE -> REQ on access. On that edge, register mem_addr, mem_we, mem_wdata and mem_wstrb, set mem_req=1, and clear the counter.
- REQ: hold mem_req and all bus outputs stable until mem_gnt. On the grant edge, mem_req drops to 0. A write goes to DONE; a read goes to WAIT_R.
- WAIT_R: on mem_rvalid, read_data_out <= extend(mem_rdata) and go to DONE. mem_rvalid is ignored in any other state.
- Timeout: the counter increments each cycle in REQ/WAIT_R. When it reaches TIMEOUT-1 without progress, drop mem_req and go to DONE with bus_err_out=1; read_data_out is set to 0 on a timed-out load.
- DONE -> IDLE unconditionally. Error pulses are high only in DONE.
- Minimum latency, grant first cycle in REQ: store 2 stall cycles; load 3 stall cycles with rvalid in the cycle after grant.
- Load extension selects byte/half by address[1:0]/address[1]:
  - 000 LB: sign-extend.
  - 001 LH: sign-extend.
  - 010 LW: full word.
  - 100 LBU: zero-extend.
  - 101 LHU: zero-extend.
  - Other codes: treated as LW.
- Store:
  - SB: wdata = {4{byte}}, wstrb = 0001<<addr[1:0].
  - SH: wdata = {2{half}}, wstrb = 0011<<{addr[1],1'b0}.
  - SW: wstrb = 1111.
  - Other codes: treated as SW.
- read_data_out holds its value until the next load completes. Stores do not modify it.
- Misaligned: halfword with addr[0]=1, word with addr[1:0]!=0.

Optional Feature:
MISALIGN_TRAP_EN.
- Defined: a misaligned access never reaches the bus and goes IDLE -> DONE directly (1 stall cycle). In DONE, misalign_err_out=1; on a load, read_data_out=0.
- Undefined: misaligned low address bits are silently cleared to the access size before use, and misalign_err_out is tied to 0.

Test Plan:
1. Reset mid-WAIT_R (reset=0 for 1 cycle, then rvalid=1 with rdata=0xDEADBEEF) -> state IDLE, read_data_out=0, stall_out=0, no bus_err_out.
2. SW addr=0x100, data=0x12345678, gnt on first REQ cycle -> mem_addr=0x100, wstrb=1111, stall_out high exactly 2 cycles.
3. SB addr=0x103, data=0xAB -> wdata=0xABABABAB, wstrb=1000. LB addr=0x103 with rdata=0x80000000 -> read_data_out=0xFFFFFF80. LBU same -> 0x00000080.
4. LH addr=0x102, rdata=0x8001_0000 -> read_data_out=0xFFFF8001; LHU -> 0x00008001. Gnt delayed 3 cycles -> mem_req and mem_addr held stable throughout.
5. Load with mem_gnt never asserted, TIMEOUT=16 -> stall 17 cycles, bus_err_out 1-cycle pulse, read_data_out=0, mem_req low after.
6. LW addr=0x102 -> with MISALIGN_TRAP_EN: no mem_req, misalign_err_out pulse, 1 stall cycle. Without it: mem_addr=0x100, normal load.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory access over a req/gnt/rvalid bus.
// Optional MISALIGN_TRAP_EN: trap misaligned accesses instead of aligning them.
module mem_access_unit #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic [2:0]  funct3_in,
    input  logic [31:0] address_in,
    input  logic [31:0] write_data_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [31:0] read_data_out,
    output logic        stall_out,
    output logic        bus_err_out,
    output logic        misalign_err_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic              r_req;
    logic              r_we;
    logic [31:0]       r_addr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_wstrb;
    logic [31:0]       r_rdata;
    logic              r_bus_err;
    logic              r_mis_err;
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        r_off;
    logic [2:0]        r_f3;

    logic              w_access;
    logic              w_is_b;
    logic              w_is_h;
    logic [1:0]        w_off;
    logic [31:0]       w_wdata;
    logic [3:0]        w_wstrb;
    logic              w_timeout;
    logic              w_trap;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_load;

    assign w_access  = MemRead_in | MemWrite_in;
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

    // Access size; stores only recognise SB/SH exactly, loads ignore sign bit
    always_comb begin
        w_is_b = 1'b0;
        w_is_h = 1'b0;
        if (MemWrite_in) begin
            w_is_b = (funct3_in == 3'b000);
            w_is_h = (funct3_in == 3'b001);
        end else begin
            w_is_b = (funct3_in[1:0] == 2'b00);
            w_is_h = (funct3_in[1:0] == 2'b01);
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic w_mis;
    assign w_mis  = (w_is_h & address_in[0]) |
                    (~w_is_b & ~w_is_h & (address_in[1:0] != 2'b00));
    assign w_trap = w_mis;
`else
    assign w_trap = 1'b0;
`endif

    // Byte offset forced to the access size, then store lane replication
    always_comb begin
        w_off   = 2'b00;
        w_wdata = write_data_in;
        w_wstrb = 4'b1111;
        unique case (1'b1)
            w_is_b: begin
                w_off   = address_in[1:0];
                w_wdata = {4{write_data_in[7:0]}};
                w_wstrb = 4'b0001 << address_in[1:0];
            end
            w_is_h: begin
                w_off   = {address_in[1], 1'b0};
                w_wdata = {2{write_data_in[15:0]}};
                w_wstrb = 4'b0011 << {address_in[1], 1'b0};
            end
            default: begin
                w_off   = 2'b00;
                w_wdata = write_data_in;
                w_wstrb = 4'b1111;
            end
        endcase
    end

    // Lane select and sign/zero extension of the returned word
    always_comb begin
        w_byte = mem_rdata[{r_off, 3'b000} +: 8];
        w_half = mem_rdata[{r_off[1], 4'b0000} +: 16];
        unique case (r_f3[1:0])
            2'b00:   w_load = {{24{w_byte[7] & ~r_f3[2]}}, w_byte};
            2'b01:   w_load = {{16{w_half[15] & ~r_f3[2]}}, w_half};
            default: w_load = mem_rdata;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_access) begin
                    w_next = w_trap ? DONE : REQ;
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    w_next = r_we ? DONE : WAIT_R;
                end else if (w_timeout) begin
                    w_next = DONE;
                end
            end
            WAIT_R: begin
                if (mem_rvalid || w_timeout) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Bus outputs, load result, timeout counter and error pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= 32'h0;
            r_wdata   <= 32'h0;
            r_wstrb   <= 4'h0;
            r_rdata   <= 32'h0;
            r_bus_err <= 1'b0;
            r_mis_err <= 1'b0;
            r_cnt     <= '0;
            r_off     <= 2'b00;
            r_f3      <= 3'b000;
        end else begin
            r_bus_err <= 1'b0;
            r_mis_err <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_access) begin
                        if (w_trap) begin
                            r_mis_err <= 1'b1;
                            if (!MemWrite_in) begin
                                r_rdata <= 32'h0;
                            end
                        end else begin
                            r_req   <= 1'b1;
                            r_we    <= MemWrite_in;
                            r_addr  <= {address_in[31:2], 2'b00};
                            r_wdata <= w_wdata;
                            r_wstrb <= MemWrite_in ? w_wstrb : 4'b0000;
                            r_cnt   <= '0;
                            r_off   <= w_off;
                            r_f3    <= funct3_in;
                        end
                    end
                end
                REQ: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (mem_gnt) begin
                        r_req <= 1'b0;
                    end else if (w_timeout) begin
                        r_req     <= 1'b0;
                        r_bus_err <= 1'b1;
                        if (!r_we) begin
                            r_rdata <= 32'h0;
                        end
                    end
                end
                WAIT_R: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (mem_rvalid) begin
                        r_rdata <= w_load;
                    end else if (w_timeout) begin
                        r_bus_err <= 1'b1;
                        r_rdata   <= 32'h0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign stall_out = ((r_state == IDLE) & w_access) |
                       (r_state == REQ) | (r_state == WAIT_R);

    assign mem_req          = r_req;
    assign mem_we           = r_we;
    assign mem_addr         = r_addr;
    assign mem_wdata        = r_wdata;
    assign mem_wstrb        = r_wstrb;
    assign read_data_out    = r_rdata;
    assign bus_err_out      = r_bus_err;
    assign misalign_err_out = r_mis_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed scoreboard bench for mem_access_unit.
// Expected load results are queued at issue and popped in DONE.
module tb_mem_access_unit;

    logic        clk;
    logic        reset;
    logic        MemRead_in;
    logic        MemWrite_in;
    logic [2:0]  funct3_in;
    logic [31:0] address_in;
    logic [31:0] write_data_in;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [31:0] read_data_out;
    logic        stall_out;
    logic        bus_err_out;
    logic        misalign_err_out;

    int          n_err;
    int          n_checks;
    logic [31:0] sb_q[$];

    int          o_stalls;
    logic        o_saw_req;
    logic        o_stable;
    logic [31:0] o_addr;
    logic [31:0] o_wdata;
    logic [3:0]  o_wstrb;
    logic        o_we;
    logic        o_berr;
    logic        o_merr;

    mem_access_unit #(
        .TIMEOUT(16),
        .CNT_W  (5)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .MemRead_in      (MemRead_in),
        .MemWrite_in     (MemWrite_in),
        .funct3_in       (funct3_in),
        .address_in      (address_in),
        .write_data_in   (write_data_in),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_wstrb       (mem_wstrb),
        .mem_gnt         (mem_gnt),
        .mem_rvalid      (mem_rvalid),
        .mem_rdata       (mem_rdata),
        .read_data_out   (read_data_out),
        .stall_out       (stall_out),
        .bus_err_out     (bus_err_out),
        .misalign_err_out(misalign_err_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // One access from IDLE through DONE; returns at posedge+1 of next IDLE
    task automatic access(input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int gdly, input logic [31:0] rd,
                          input logic [31:0] exp);
        int   reqcyc;
        logic rv_next;
        logic done;
        reqcyc    = 0;
        rv_next   = 1'b0;
        done      = 1'b0;
        o_stalls  = 0;
        o_saw_req = 1'b0;
        o_stable  = 1'b1;
        o_addr    = 32'h0;
        o_wdata   = 32'h0;
        o_wstrb   = 4'h0;
        o_we      = 1'b0;
        sb_q.push_back(exp);
        MemRead_in    = ~wr;
        MemWrite_in   = wr;
        funct3_in     = f3;
        address_in    = addr;
        write_data_in = wd;
        for (int c = 0; c < 40 && !done; c++) begin
            mem_gnt    = 1'b0;
            mem_rvalid = rv_next;
            mem_rdata  = rv_next ? rd : 32'h0;
            rv_next    = 1'b0;
            if (mem_req) begin
                if (!o_saw_req) begin
                    o_saw_req = 1'b1;
                    o_addr    = mem_addr;
                    o_wdata   = mem_wdata;
                    o_wstrb   = mem_wstrb;
                    o_we      = mem_we;
                end else if (mem_addr !== o_addr || mem_wdata !== o_wdata ||
                             mem_wstrb !== o_wstrb || mem_we !== o_we) begin
                    o_stable = 1'b0;
                end
                if (gdly >= 0 && reqcyc == gdly) begin
                    mem_gnt = 1'b1;
                    rv_next = ~wr;
                end
                reqcyc++;
            end
            #1;
            if (!stall_out) begin
                done = 1'b1;
            end else begin
                o_stalls++;
                @(posedge clk);
                #1;
            end
        end
        chk("done_reached", 32'(done), 32'd1);
        o_berr        = bus_err_out;
        o_merr        = misalign_err_out;
        MemRead_in    = 1'b0;
        MemWrite_in   = 1'b0;
        mem_gnt       = 1'b0;
        mem_rvalid    = 1'b0;
        mem_rdata     = 32'h0;
        chk("rd_data", read_data_out, sb_q.pop_front());
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_err         = 0;
        n_checks      = 0;
        reset         = 1'b0;
        MemRead_in    = 1'b0;
        MemWrite_in   = 1'b0;
        funct3_in     = 3'b000;
        address_in    = 32'h0;
        write_data_in = 32'h0;
        mem_gnt       = 1'b0;
        mem_rvalid    = 1'b0;
        mem_rdata     = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_stall", 32'(stall_out), 32'd0);
        chk("rst_rdata", read_data_out, 32'h0);
        chk("rst_wstrb", 32'(mem_wstrb), 32'd0);
        chk("rst_berr", 32'(bus_err_out), 32'd0);
        chk("rst_merr", 32'(misalign_err_out), 32'd0);

        access(1'b0, 3'b010, 32'h200, 32'h0, 0, 32'h11223344, 32'h11223344);
        chk("lw0_stalls", 32'(o_stalls), 32'd3);
        chk("lw0_addr", o_addr, 32'h200);
        chk("lw0_wstrb", 32'(o_wstrb), 32'd0);

        MemRead_in = 1'b1;
        funct3_in  = 3'b010;
        address_in = 32'h300;
        @(posedge clk);
        #1;
        chk("rstm_req_up", 32'(mem_req), 32'd1);
        mem_gnt = 1'b1;
        @(posedge clk);
        #1;
        mem_gnt = 1'b0;
        chk("rstm_wait_stall", 32'(stall_out), 32'd1);
        reset      = 1'b0;
        MemRead_in = 1'b0;
        @(posedge clk);
        #1;
        reset      = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        chk("rstm_rdata", read_data_out, 32'h0);
        chk("rstm_stall", 32'(stall_out), 32'd0);
        chk("rstm_berr", 32'(bus_err_out), 32'd0);
        chk("rstm_req", 32'(mem_req), 32'd0);

        access(1'b1, 3'b010, 32'h100, 32'h12345678, 0, 32'h0, 32'h0);
        chk("sw_stalls", 32'(o_stalls), 32'd2);
        chk("sw_addr", o_addr, 32'h100);
        chk("sw_wstrb", 32'(o_wstrb), 32'hF);
        chk("sw_wdata", o_wdata, 32'h12345678);
        chk("sw_we", 32'(o_we), 32'd1);
        chk("sw_berr", 32'(o_berr), 32'd0);

        access(1'b1, 3'b000, 32'h103, 32'h000000AB, 0, 32'h0, 32'h0);
        chk("sb_wdata", o_wdata, 32'hABABABAB);
        chk("sb_wstrb", 32'(o_wstrb), 32'h8);
        chk("sb_addr", o_addr, 32'h100);

        access(1'b0, 3'b000, 32'h103, 32'h0, 0, 32'h80000000, 32'hFFFFFF80);
        chk("lb_stalls", 32'(o_stalls), 32'd3);
        chk("lb_we", 32'(o_we), 32'd0);

        access(1'b1, 3'b001, 32'h102, 32'h0000BEEF, 0, 32'h0, 32'hFFFFFF80);
        chk("sh_wdata", o_wdata, 32'hBEEFBEEF);
        chk("sh_wstrb", 32'(o_wstrb), 32'hC);

        access(1'b0, 3'b100, 32'h103, 32'h0, 0, 32'h80000000, 32'h00000080);
        access(1'b0, 3'b001, 32'h102, 32'h0, 0, 32'h80010000, 32'hFFFF8001);

        access(1'b0, 3'b101, 32'h102, 32'h0, 3, 32'h80010000, 32'h00008001);
        chk("lhu_stalls", 32'(o_stalls), 32'd6);
        chk("lhu_stable", 32'(o_stable), 32'd1);
        chk("lhu_addr", o_addr, 32'h100);

        access(1'b0, 3'b010, 32'h400, 32'h0, -1, 32'h0, 32'h0);
        chk("to_stalls", 32'(o_stalls), 32'd17);
        chk("to_berr", 32'(o_berr), 32'd1);
        chk("to_berr_pulse", 32'(bus_err_out), 32'd0);
        chk("to_req_low", 32'(mem_req), 32'd0);

`ifdef MISALIGN_TRAP_EN
        access(1'b0, 3'b010, 32'h102, 32'h0, 0, 32'hCAFEF00D, 32'h0);
        chk("mis_lw_stalls", 32'(o_stalls), 32'd1);
        chk("mis_lw_req", 32'(o_saw_req), 32'd0);
        chk("mis_lw_merr", 32'(o_merr), 32'd1);
        chk("mis_merr_pulse", 32'(misalign_err_out), 32'd0);
        access(1'b0, 3'b001, 32'h101, 32'h0, 0, 32'h12348765, 32'h0);
        chk("mis_lh_merr", 32'(o_merr), 32'd1);
`else
        access(1'b0, 3'b010, 32'h102, 32'h0, 0, 32'hCAFEF00D, 32'hCAFEF00D);
        chk("mis_lw_stalls", 32'(o_stalls), 32'd3);
        chk("mis_lw_addr", o_addr, 32'h100);
        chk("mis_lw_merr", 32'(o_merr), 32'd0);
        access(1'b0, 3'b001, 32'h101, 32'h0, 0, 32'h12348765, 32'hFFFF8765);
        chk("mis_lh_merr", 32'(o_merr), 32'd0);
`endif

        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
